// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked ALU with 1-bit/clock iterative shifter
// Optional CARRY/OVF outputs are built when SEQ_ALU_FLAGS_EN is defined.
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       op,
    input  logic             sub,
    input  logic             ari,
    input  logic             lef,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             zero
`ifdef SEQ_ALU_FLAGS_EN
    ,
    output logic             carry,
    output logic             ovf
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_next;
    logic             live;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   cnt;
    logic             ari_q, lef_q;
    logic             accept, is_shift;
    logic [WIDTH-1:0] bx, res, step;

    assign accept    = in_valid && in_ready;
    assign is_shift  = (op == 2'd3) && (shamt != '0);
    assign bx        = sub ? ~b : b;
    assign in_ready  = live && (state == IDLE);
    assign out_valid = (state == DONE);

`ifdef SEQ_ALU_FLAGS_EN
    logic [WIDTH:0] sum;
    logic           carry_d, ovf_d;
    // Subtraction is a + ~b + 1, so the carry-out is already the no-borrow flag.
    assign sum     = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
    assign carry_d = (op == 2'd0) && sum[WIDTH];
    assign ovf_d   = (op == 2'd0) && (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
`else
    logic [WIDTH-1:0] sum;
    assign sum = a + bx + {{(WIDTH-1){1'b0}}, sub};
`endif

    always_comb begin
        res = a;
        case (op)
            2'd0:    res = sum[WIDTH-1:0];
            2'd1:    res = ~(a & b);
            2'd2:    res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: res = a;
        endcase
    end

    always_comb begin
        step = {1'b0, work[WIDTH-1:1]};
        if (lef_q)
            step = {work[WIDTH-2:0], 1'b0};
        else if (ari_q)
            step = {work[WIDTH-1], work[WIDTH-1:1]};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = is_shift ? SHIFT : DONE;
            SHIFT:   if (cnt == SHW'(1)) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            live  <= 1'b0;
            work  <= '0;
            cnt   <= '0;
            ari_q <= 1'b0;
            lef_q <= 1'b0;
            c     <= '0;
            zero  <= 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
            carry <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            live  <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_shift) begin
                            work  <= a;
                            cnt   <= shamt;
                            ari_q <= ari;
                            lef_q <= lef;
                        end else begin
                            c    <= res;
                            zero <= (res == '0);
`ifdef SEQ_ALU_FLAGS_EN
                            carry <= carry_d;
                            ovf   <= ovf_d;
`endif
                        end
                    end
                end
                SHIFT: begin
                    work <= step;
                    cnt  <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        c    <= step;
                        zero <= (step == '0);
`ifdef SEQ_ALU_FLAGS_EN
                        carry <= 1'b0;
                        ovf   <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - vector table, random model comparison and corner sequences for seq_alu
module tb_seq_alu;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0, b = '0;
    logic [3:0]    shamt = '0;
    logic [1:0]    op = '0;
    logic          sub = 1'b0, ari = 1'b0, lef = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  c;
    logic          zero;
`ifdef SEQ_ALU_FLAGS_EN
    logic          carry, ovf;
`endif

    int vectors = 0;
    int miscompares = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .shamt(shamt), .op(op), .sub(sub), .ari(ari), .lef(lef),
        .out_valid(out_valid), .out_ready(out_ready), .c(c), .zero(zero)
`ifdef SEQ_ALU_FLAGS_EN
        , .carry(carry), .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic       sub, ari, lef;
        logic [W-1:0] a, b;
        logic [3:0] shamt;
        logic [W-1:0] c;
        logic       z;
        int         lat;
        logic       cy, ov;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Reference: results straight from the arithmetic definitions
    task automatic model(input logic [1:0] m_op, input logic m_sub, m_ari, m_lef,
                         input logic [W-1:0] m_a, m_b, input logic [3:0] m_sh,
                         output logic [W-1:0] r, output int lat, output logic cy, ov);
        logic signed [W-1:0] sa;
        int s;
        cy = 1'b0; ov = 1'b0; lat = 1;
        case (m_op)
            2'd0: begin
                if (m_sub) begin
                    r  = W'(m_a - m_b);
                    cy = (m_a >= m_b);
                    s  = int'($signed(m_a)) - int'($signed(m_b));
                end else begin
                    r  = W'(m_a + m_b);
                    cy = ((32'(m_a) + 32'(m_b)) > 32'hFFFF);
                    s  = int'($signed(m_a)) + int'($signed(m_b));
                end
                ov = (s > 32767) || (s < -32768);
            end
            2'd1: r = ~(m_a & m_b);
            2'd2: r = (m_a < m_b) ? W'(1) : W'(0);
            default: begin
                sa = m_a;
                if (m_lef)      r = m_a << m_sh;
                else if (m_ari) r = sa >>> m_sh;
                else            r = m_a >> m_sh;
                lat = (m_sh == 0) ? 1 : int'(m_sh) + 1;
            end
        endcase
    endtask

    task automatic drive(input logic [1:0] d_op, input logic d_sub, d_ari, d_lef,
                         input logic [W-1:0] d_a, d_b, input logic [3:0] d_sh);
        op = d_op; sub = d_sub; ari = d_ari; lef = d_lef; a = d_a; b = d_b; shamt = d_sh;
    endtask

    // Issue one op, scramble inputs after accept, wait for result; returns latency
    task automatic do_op(input logic [1:0] d_op, input logic d_sub, d_ari, d_lef,
                         input logic [W-1:0] d_a, d_b, input logic [3:0] d_sh,
                         output logic [W-1:0] r, output logic z, output int lat,
                         output logic cy, output logic ov);
        int guard;
        drive(d_op, d_sub, d_ari, d_lef, d_a, d_b, d_sh);
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 50) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drive(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              W'($urandom), W'($urandom), 4'($urandom));
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        r = c; z = zero;
`ifdef SEQ_ALU_FLAGS_EN
        cy = carry; ov = ovf;
`else
        cy = 1'b0; ov = 1'b0;
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        logic [W-1:0] r, er;
        logic z, cy, ov, ecy, eov;
        int lat, elat, cnt_valid;

        vecs[0]  = '{2'd0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 4'd0,  16'h0000, 1'b1, 1,  1'b1, 1'b0};
        vecs[1]  = '{2'd0, 1'b1, 1'b0, 1'b0, 16'h0005, 16'h0007, 4'd0,  16'hFFFE, 1'b0, 1,  1'b0, 1'b0};
        vecs[2]  = '{2'd2, 1'b0, 1'b0, 1'b0, 16'h0003, 16'h0005, 4'd0,  16'h0001, 1'b0, 1,  1'b0, 1'b0};
        vecs[3]  = '{2'd2, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h0003, 4'd0,  16'h0000, 1'b1, 1,  1'b0, 1'b0};
        vecs[4]  = '{2'd1, 1'b0, 1'b0, 1'b0, 16'hFF00, 16'h0F0F, 4'd0,  16'hF0FF, 1'b0, 1,  1'b0, 1'b0};
        vecs[5]  = '{2'd3, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 4'd0,  16'h1234, 1'b0, 1,  1'b0, 1'b0};
        vecs[6]  = '{2'd3, 1'b0, 1'b1, 1'b0, 16'h8000, 16'h0000, 4'd15, 16'hFFFF, 1'b0, 16, 1'b0, 1'b0};
        vecs[7]  = '{2'd3, 1'b0, 1'b0, 1'b0, 16'h8000, 16'h0000, 4'd15, 16'h0001, 1'b0, 16, 1'b0, 1'b0};
        vecs[8]  = '{2'd3, 1'b0, 1'b0, 1'b1, 16'h0001, 16'h0000, 4'd4,  16'h0010, 1'b0, 5,  1'b0, 1'b0};
        vecs[9]  = '{2'd0, 1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 4'd0,  16'h8000, 1'b0, 1,  1'b0, 1'b1};
        vecs[10] = '{2'd0, 1'b1, 1'b0, 1'b0, 16'h8000, 16'h0001, 4'd0,  16'h7FFF, 1'b0, 1,  1'b1, 1'b1};
        vecs[11] = '{2'd3, 1'b0, 1'b1, 1'b1, 16'h8001, 16'h0000, 4'd1,  16'h0002, 1'b0, 2,  1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_c", c, 0);
        check("rst_zero", zero, 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", in_ready, 1);

        // Directed table
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].sub, vecs[i].ari, vecs[i].lef,
                  vecs[i].a, vecs[i].b, vecs[i].shamt, r, z, lat, cy, ov);
            check($sformatf("vec%0d_c", i), r, vecs[i].c);
            check($sformatf("vec%0d_zero", i), z, vecs[i].z);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
`ifdef SEQ_ALU_FLAGS_EN
            check($sformatf("vec%0d_carry", i), cy, vecs[i].cy);
            check($sformatf("vec%0d_ovf", i), ov, vecs[i].ov);
`endif
        end

        // Random ops against the model
        for (int i = 0; i < 150; i++) begin
            logic [1:0] rop;
            logic rsub, rari, rlef;
            logic [W-1:0] ra, rb;
            logic [3:0] rsh;
            rop = 2'($urandom); rsub = 1'($urandom); rari = 1'($urandom); rlef = 1'($urandom);
            ra = W'($urandom); rb = ($urandom_range(0, 7) == 0) ? ra : W'($urandom);
            rsh = 4'($urandom);
            model(rop, rsub, rari, rlef, ra, rb, rsh, er, elat, ecy, eov);
            do_op(rop, rsub, rari, rlef, ra, rb, rsh, r, z, lat, cy, ov);
            check($sformatf("rnd%0d_c", i), r, er);
            check($sformatf("rnd%0d_zero", i), z, (er == '0));
            check($sformatf("rnd%0d_lat", i), lat, elat);
`ifdef SEQ_ALU_FLAGS_EN
            check($sformatf("rnd%0d_carry", i), cy, ecy);
            check($sformatf("rnd%0d_ovf", i), ov, eov);
`endif
        end

        // Backpressure in DONE: result held, second request ignored until drained
        out_ready = 1'b0;
        drive(2'd0, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0001, 4'd0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive(2'd1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 4'd0);
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_c", c, 16'h0002);
            check("bp_zero", zero, 0);
            check("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_drained", out_valid, 0);
        check("bp_idle_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_second_valid", out_valid, 1);
        check("bp_second_c", c, 16'h0000);
        check("bp_second_zero", zero, 1);
        @(posedge clk); #1;

        // Reset in the middle of a long shift
        drive(2'd3, 1'b0, 1'b1, 1'b0, 16'h8000, 16'h0000, 4'd15);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_c", c, 0);
        check("mid_rst_in_ready", in_ready, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rel_in_ready", in_ready, 1);
        cnt_valid = 0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) cnt_valid++;
            @(posedge clk); #1;
        end
        check("no_stale_result", cnt_valid, 0);
        check("post_rst_c", c, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
